// File: rtl/mem_pkg.sv
// Shared memory-system constants and the data memory FSM state type.
// The L1 data cache imports the same block-width constants.
package mem_pkg;

   localparam int unsigned MEM_ADDR_W  = 32;
   localparam int unsigned BLOCK_W     = 256;
   localparam int unsigned BLOCK_OFF_W = 5;    // byte offset inside a 32-byte block
   localparam int unsigned MEM_DEPTH   = 512;
   localparam int unsigned MEM_LATENCY = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_e;

endpackage : mem_pkg

// File: rtl/data_memory.sv
// Off-chip main data memory model: DEPTH blocks of DATA_W bits, whole-block
// reads/writes over an enable/ack handshake with a fixed LATENCY.
// Ports:
//   clk_i    - clock, all state changes on the rising edge
//   rst_i    - synchronous active-high reset (storage is never cleared)
//   addr_i   - byte address; block index = addr_i[IDX_W+4:5], other bits ignored
//   data_i   - write block
//   enable_i - request valid, held with stable addr/data/write until ack
//   write_i  - 1 = write block, 0 = read block
//   ack_o    - one-cycle completion pulse
//   data_o   - read block, valid in the ack cycle, held until next completion
module data_memory
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = MEM_ADDR_W,
   parameter int unsigned DATA_W  = BLOCK_W,
   parameter int unsigned DEPTH   = MEM_DEPTH,
   parameter int unsigned LATENCY = MEM_LATENCY
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   output logic              ack_o,
   output logic [DATA_W-1:0] data_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   // Block storage; benches preload and inspect it by hierarchical name.
   logic [DATA_W-1:0] memory [0:DEPTH-1];

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              ack_q,   ack_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wr_q,    wr_d;
   logic              mem_we_c;

   // Address bits outside the block index alias or select bytes; deliberately dropped.
   logic unused_addr_c;
   assign unused_addr_c = ^{addr_i[ADDR_W-1:IDX_W+BLOCK_OFF_W], addr_i[BLOCK_OFF_W-1:0]};

   // Next-state, counter and completion logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ack_d    = 1'b0;
      data_d   = data_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
      mem_we_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i) begin
               idx_d   = addr_i[IDX_W+BLOCK_OFF_W-1:BLOCK_OFF_W];
               wdata_d = data_i;
               wr_d    = write_i;
               cnt_d   = CNT_W'(1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == CNT_W'(LATENCY - 1)) begin
               ack_d   = 1'b1;
               cnt_d   = '0;
               state_d = DONE;
               if (wr_q) begin
                  mem_we_c = 1'b1;
                  data_d   = wdata_q;
               end else begin
                  data_d   = memory[idx_q];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            // Held enable is not re-sampled here; next acceptance is from IDLE.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
      end
   end

   // Array write; reset at the completion edge abandons the write.
   always_ff @(posedge clk_i) begin
      if (mem_we_c && !rst_i) begin
         memory[idx_q] <= wdata_q;
      end
   end

   assign ack_o  = ack_q;
   assign data_o = data_q;

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: scoreboard of expected read/write
// results, one task per scenario.
module tb_data_memory;
   import mem_pkg::*;

   localparam int unsigned LAT = MEM_LATENCY;
   localparam int          BUDGET = 50;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  addr_i;
   logic [255:0] data_i;
   logic         enable_i;
   logic         write_i;
   logic         ack_o;
   logic [255:0] data_o;

   logic [255:0] exp_q [$];
   int           n_checks = 0;
   int           n_fail   = 0;

   data_memory dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .enable_i (enable_i),
      .write_i  (write_i),
      .ack_o    (ack_o),
      .data_o   (data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic issue(input logic [31:0] a, input logic w, input logic [255:0] d);
      addr_i   = a;
      write_i  = w;
      data_i   = d;
      enable_i = 1'b1;
   endtask

   // Drop enable and let DONE return to IDLE.
   task automatic release_req();
      enable_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic wait_ack(output int cycles, output bit got);
      cycles = 0;
      got    = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         @(posedge clk_i); #1;
         cycles++;
         if (ack_o) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_exp(output logic [255:0] e);
      if (exp_q.size() == 0) e = 'x;
      else e = exp_q.pop_front();
   endtask

   task automatic test_reset();
      rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
      dut.memory[0] = 256'h5;
      repeat (2) @(posedge clk_i);
      #1;
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack_o); end
      n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_o); end
      n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
      n_checks++; if (dut.cnt_q !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", dut.cnt_q); end
      n_checks++; if (dut.memory[0] !== 256'h5) begin n_fail++; $display("FAIL reset_keeps_mem got %h want 5", dut.memory[0]); end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_read_latency();
      int cyc; bit got; logic [255:0] e;
      issue(32'h0000, 1'b0, '0);
      exp_q.push_back(256'h5);
      wait_ack(cyc, got);
      pop_exp(e);
      n_checks++; if (!got || cyc != LAT) begin n_fail++; $display("FAIL read_latency got %0d (ack %b) want %0d", cyc, got, LAT); end
      n_checks++; if (data_o !== e) begin n_fail++; $display("FAIL read_data got %h want %h", data_o, e); end
      release_req();
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle got %b want 0", ack_o); end
      n_checks++; if (data_o !== e) begin n_fail++; $display("FAIL data_held got %h want %h", data_o, e); end
   endtask

   task automatic test_write_readback();
      int cyc; bit got; logic [255:0] e;
      issue(32'h0400, 1'b1, 256'hDEAD_BEEF);
      exp_q.push_back(256'hDEAD_BEEF);
      wait_ack(cyc, got);
      pop_exp(e);
      n_checks++; if (!got) begin n_fail++; $display("FAIL write_ack got none want ack"); end
      n_checks++; if (data_o !== e) begin n_fail++; $display("FAIL write_data_o got %h want %h", data_o, e); end
      n_checks++; if (dut.memory[32] !== e) begin n_fail++; $display("FAIL write_mem32 got %h want %h", dut.memory[32], e); end
      release_req();
      issue(32'h0400, 1'b0, '0);
      exp_q.push_back(256'hDEAD_BEEF);
      wait_ack(cyc, got);
      pop_exp(e);
      n_checks++; if (!got || data_o !== e) begin n_fail++; $display("FAIL readback got %h (ack %b) want %h", data_o, got, e); end
      release_req();
   endtask

   task automatic test_alias();
      int cyc; bit got; logic [255:0] e; logic [255:0] rnd;
      for (int i = 0; i < 8; i++) rnd[i*32 +: 32] = $urandom();
      dut.memory[1] = rnd;
      issue(32'h0000_4020, 1'b0, '0);
      exp_q.push_back(rnd);
      wait_ack(cyc, got);
      pop_exp(e);
      n_checks++; if (!got || data_o !== e) begin n_fail++; $display("FAIL alias_block1 got %h (ack %b) want %h", data_o, got, e); end
      release_req();
      issue(32'h0000_001F, 1'b0, '0);
      exp_q.push_back(256'h5);
      wait_ack(cyc, got);
      pop_exp(e);
      n_checks++; if (!got || data_o !== e) begin n_fail++; $display("FAIL offset_block0 got %h (ack %b) want %h", data_o, got, e); end
      release_req();
   endtask

   task automatic test_held_enable();
      int acks = 0; int last = -1; logic prev = 1'b0; logic [255:0] e;
      issue(32'h0000, 1'b0, '0);
      repeat (3) exp_q.push_back(256'h5);
      for (int i = 0; i < 3 * (LAT + 1); i++) begin
         @(posedge clk_i); #1;
         if (ack_o) begin
            acks++;
            n_checks++; if (prev) begin n_fail++; $display("FAIL held_consecutive_ack at cycle %0d want single", i); end
            if (last >= 0) begin
               n_checks++; if (i - last != int'(LAT + 1)) begin n_fail++; $display("FAIL held_spacing got %0d want %0d", i - last, LAT + 1); end
            end
            last = i;
            pop_exp(e);
            n_checks++; if (data_o !== e) begin n_fail++; $display("FAIL held_data got %h want %h", data_o, e); end
         end
         prev = ack_o;
      end
      enable_i = 1'b0;
      n_checks++; if (acks != 3) begin n_fail++; $display("FAIL held_ack_count got %0d want 3", acks); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_mid_busy_change();
      int cyc; bit got; logic [255:0] e;
      dut.memory[7] = '0;
      dut.memory[8] = 256'hC0FFEE;
      issue(32'd7 << 5, 1'b1, 256'hAAAA_5555);
      exp_q.push_back(256'hAAAA_5555);
      repeat (3) @(posedge clk_i);
      #1;
      addr_i = 32'd8 << 5; data_i = 256'hBBBB; write_i = 1'b0; enable_i = 1'b0;
      wait_ack(cyc, got);
      pop_exp(e);
      n_checks++; if (!got || cyc + 3 != int'(LAT)) begin n_fail++; $display("FAIL midbusy_latency got %0d (ack %b) want %0d", cyc + 3, got, LAT); end
      n_checks++; if (data_o !== e) begin n_fail++; $display("FAIL midbusy_data got %h want %h", data_o, e); end
      n_checks++; if (dut.memory[7] !== e) begin n_fail++; $display("FAIL midbusy_mem7 got %h want %h", dut.memory[7], e); end
      n_checks++; if (dut.memory[8] !== 256'hC0FFEE) begin n_fail++; $display("FAIL midbusy_mem8 got %h want c0ffee", dut.memory[8]); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset_mid_busy();
      int acks = 0;
      dut.memory[9] = 256'h1234_5678;
      issue(32'd9 << 5, 1'b1, 256'h9999);
      repeat (5) @(posedge clk_i);
      #1;
      rst_i = 1'b1; enable_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL rstbusy_ack got %b want 0", ack_o); end
      n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL rstbusy_state got %0d want IDLE", dut.state_q); end
      n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL rstbusy_data got %h want 0", data_o); end
      for (int i = 0; i < int'(LAT) + 2; i++) begin
         @(posedge clk_i); #1;
         if (ack_o) acks++;
      end
      n_checks++; if (acks != 0) begin n_fail++; $display("FAIL rstbusy_stray_ack got %0d want 0", acks); end
      n_checks++; if (dut.memory[9] !== 256'h1234_5678) begin n_fail++; $display("FAIL rstbusy_mem9 got %h want 12345678", dut.memory[9]); end
      n_checks++; if (dut.memory[0] !== 256'h5) begin n_fail++; $display("FAIL rstbusy_mem0 got %h want 5", dut.memory[0]); end
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_write_readback();
      test_alias();
      test_held_enable();
      test_mid_busy_change();
      test_reset_mid_busy();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_data_memory
